// File: rtl/alu_exec_unit_pkg.sv
// Shared constants, state encoding and single-cycle op helper for alu_exec_unit.
// ALU_MUL_FAST_EN selects a combinational multiplier in the op mux.
package alu_exec_unit_pkg;

    localparam int unsigned Xlen     = 32;
    localparam int unsigned CtrlW    = 4;
    localparam int unsigned MulIters = 32;
    localparam int unsigned MulCntW  = 5;

    localparam logic [CtrlW-1:0] CtrlAnd  = 4'd0;
    localparam logic [CtrlW-1:0] CtrlXor  = 4'd1;
    localparam logic [CtrlW-1:0] CtrlSll  = 4'd2;
    localparam logic [CtrlW-1:0] CtrlAdd  = 4'd3;
    localparam logic [CtrlW-1:0] CtrlSub  = 4'd4;
    localparam logic [CtrlW-1:0] CtrlMul  = 4'd5;
    localparam logic [CtrlW-1:0] CtrlAddi = 4'd6;
    localparam logic [CtrlW-1:0] CtrlSrai = 4'd7;
    localparam logic [CtrlW-1:0] CtrlLwsw = 4'd8;
    localparam logic [CtrlW-1:0] CtrlBeq  = 4'd9;

    typedef enum logic {
        StIdle,
        StMulRun
    } alu_state_e;

    // Result of every op that completes in one cycle; illegal codes yield 0.
    function automatic logic [Xlen-1:0] alu_single(input logic [CtrlW-1:0] ctrl,
                                                   input logic [Xlen-1:0]  a,
                                                   input logic [Xlen-1:0]  b);
        logic [Xlen-1:0] res;
        res = '0;
        case (ctrl)
            CtrlAnd:  res = a & b;
            CtrlXor:  res = a ^ b;
            CtrlSll:  res = a << b[4:0];
            CtrlAdd,
            CtrlAddi,
            CtrlLwsw: res = a + b;
            CtrlSub,
            CtrlBeq:  res = a - b;
            CtrlSrai: res = $signed(a) >>> b[4:0];
`ifdef ALU_MUL_FAST_EN
            CtrlMul:  res = a * b;
`endif
            default:  res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative 32-step shift-add multiplier: one partial product per cycle after start.
module alu_exec_unit_mul_iter
    import alu_exec_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [Xlen-1:0] multiplicand_i,
    input  logic [Xlen-1:0] multiplier_i,
    output logic            done_o,
    output logic [Xlen-1:0] product_o
);

    logic               busy_q;
    logic [MulCntW-1:0] cnt_q;
    logic [Xlen-1:0]    acc_q;
    logic [Xlen-1:0]    mcand_q;
    logic [Xlen-1:0]    mplier_q;
    logic [Xlen-1:0]    acc_step;

    assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    // Product is taken from the step being completed so the top can register it on this edge.
    assign done_o    = busy_q && (cnt_q == MulCntW'(MulIters - 1));
    assign product_o = acc_step;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (flush_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= multiplicand_i;
            mplier_q <= multiplier_i;
        end else if (busy_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + MulCntW'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result; MUL is iterative unless ALU_MUL_FAST_EN is defined,
// in which case MUL is single-cycle and ready_o is constant 1.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ctrl_i,
    input  logic [XLEN-1:0]  data1_i,
    input  logic [XLEN-1:0]  data2_i,
    output logic             valid_o,
    output logic [XLEN-1:0]  result_o,
    output logic             zero_o
);

    logic            accept;
    logic [XLEN-1:0] op_result;
    logic            valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;

    assign accept    = valid_i && ready_o && !flush_i;
    assign op_result = alu_single(ctrl_i, data1_i, data2_i);

    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;

`ifdef ALU_MUL_FAST_EN

    assign ready_o = 1'b1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            result_q <= op_result;
            zero_q   <= (op_result == '0);
        end else begin
            valid_q <= 1'b0;
        end
    end

`else

    alu_state_e      state_q;
    alu_state_e      state_d;
    logic            is_mul;
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    assign is_mul = (ctrl_i == CtrlMul);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:   if (accept && is_mul) state_d = StMulRun;
                StMulRun: if (mul_done)         state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // ready_o comes from the state register only; no path from valid_i.
    always_comb begin
        ready_o   = (state_q == StIdle);
        mul_start = accept && is_mul;
    end

    alu_exec_unit_mul_iter u_mul_iter (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (mul_start),
        .flush_i        (flush_i),
        .multiplicand_i (data1_i),
        .multiplier_i   (data2_i),
        .done_o         (mul_done),
        .product_o      (mul_product)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if ((state_q == StMulRun) && mul_done) begin
            valid_q  <= 1'b1;
            result_q <= mul_product;
            zero_q   <= (mul_product == '0);
        end else if (accept && !is_mul) begin
            valid_q  <= 1'b1;
            result_q <= op_result;
            zero_q   <= (op_result == '0);
        end else begin
            valid_q <= 1'b0;
        end
    end

`endif

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and returns a registered result. Single-cycle ops complete with one-cycle latency. MUL runs on an iterative 32-step shift-add datapath and back-pressures the pipeline through a ready/valid handshake. Sits between the ID/EX pipeline register and the EX/MEM pipeline register; `ready_o` feeds the hazard unit as the EX stall source.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  abort any in-flight op; highest priority after reset.
- `valid_i`  in  1  request valid.
- `ready_o`  out  1  unit can accept; a request is accepted on an edge where `valid_i && ready_o`.
- `ctrl_i`  in  4  ALU control code (see Operation).
- `data1_i`  in  XLEN  operand A (rs1).
- `data2_i`  in  XLEN  operand B (rs2 or immediate).
- `valid_o`  out  1  one-cycle pulse: `result_o` and `zero_o` are new.
- `result_o`  out  XLEN  registered result; holds until the next completion.
- `zero_o`  out  1  registered `(result == 0)` for the same completion.

## Operation
- Control codes (4-bit):
  - AND=0: A&B
  - XOR=1: A^B
  - SLL=2: A<<B[4:0]
  - ADD=3: A+B
  - SUB=4: A−B
  - MUL=5: low 32 bits of A×B
  - ADDI=6: A+B
  - SRAI=7: A>>>B[4:0], arithmetic
  - LWSW=8: A+B, address
  - BEQ=9: A−B
  - 10..15 are illegal: result 0, `zero_o`=1, completes like a single-cycle op.
- All arithmetic is modulo 2^32; overflow is ignored. Shift amount uses only B[4:0].
- States:
  - IDLE: `ready_o`=1.
  - MUL_RUN: `ready_o`=0.
- Transitions:
  - IDLE → IDLE on an accepted non-MUL op; the result is registered and `valid_o` is set.
  - IDLE → MUL_RUN on an accepted MUL; the operands are latched, the accumulator is cleared, and the 5-bit counter is set to 0.
  - In MUL_RUN, each cycle: if multiplier[0], acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count += 1.
  - MUL_RUN → IDLE on the edge where count==31 completes its step; `result_o`=acc and `valid_o`=1.
- `flush_i`=1 on any edge does the following:
  - State becomes IDLE, the counter and accumulator clear, and `valid_o`=0.
  - `result_o`/`zero_o` hold their old values.
  - A request presented in the same cycle is dropped.
- `valid_i` in MUL_RUN is ignored; the upstream stage holds it.

## Timing
- Reset values: state IDLE, `ready_o`=1, `valid_o`=0, `result_o`=0, `zero_o`=1, counter 0, accumulator 0.
- Non-MUL latency: accept at edge N; `valid_o` is high and the result is visible for the cycle after edge N.
- Back-to-back non-MUL ops: one per cycle; `valid_o` stays high across consecutive completions.
- MUL latency: accept at edge N; `ready_o`=0 after N; completion at edge N+32; `valid_o` is high for the cycle after N+32, with `ready_o`=1 in that same cycle.
  - A new request may be accepted in that completion cycle.
- Reset asserted mid-MUL: immediately return to the reset values with no completion.
- `ready_o` depends only on registered state; there is no combinational path from `valid_i`.

## Configuration
- `ALU_MUL_FAST_EN` defined: MUL is single-cycle using a combinational multiplier, with the same latency as ADD.
  - MUL_RUN and the sub-module are not instantiated; `ready_o` is constant 1 after reset.
- `ALU_MUL_FAST_EN` undefined: the 32-cycle iterative behaviour above.

## Structure
- The shared define file holds:
  - the control-code constants (AND..BEQ), their width (4),
  - the state encodings,
  - the MUL iteration count (32).
- Sub-module `mul_iter`:
  - Contains the counter, accumulator, multiplicand/multiplier shift registers, and `start`/`flush`/`done` ports.
  - The top module holds the state, the op mux, and the output registers.

## Test plan
- ADD A=5, B=7 → `valid_o` 1 cycle after accept, `result_o`=12, `zero_o`=0.
- BEQ A=B=0x0000_0009 → `result_o`=0, `zero_o`=1. SUB 3−5 → `result_o`=0xFFFF_FFFE.
- SRAI A=0x8000_0000, B=4 → 0xF800_0000. SLL A=1, B=0x21 → 0x2 (only B[4:0] used).
- MUL A=0x1234, B=0x10:
  - `ready_o` is low for 32 cycles and `valid_o` pulses once with 0x12340.
  - An ADD accepted in the completion cycle returns its result on the next cycle.
- MUL 0xFFFF_FFFF × 0xFFFF_FFFF → 0x0000_0001. MUL × 0 → 0 with `zero_o`=1 and the full 32-cycle latency.
- Abort cases:
  - `flush_i` on the 10th MUL_RUN cycle → no `valid_o`; `ready_o`=1 next cycle; `result_o` unchanged.
  - `rst_i` low mid-MUL → all outputs at their reset values asynchronously.
  - Illegal code 0xF → `result_o`=0 after 1 cycle.
